// File: rtl/sha_arb_pkg.sv
// Shared types and constants for the SHA-256 requester arbiter.
// Optional watchdog is enabled by defining SHA_ARB_TIMEOUT_EN.
package sha_arb_pkg;

    localparam int BLK_W       = 512;
    localparam int HASH_W      = 256;
    localparam int DEF_NREQ    = 2;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/sha_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr.
// Output is one-hot, or all zero when no request is active.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win
);

    always_comb begin
        int   idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_arbiter.sv
// Shares one SHA-256 core among NREQ requesters with round-robin grants.
// Define SHA_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
module sha_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*BLK_W-1:0] blk,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ack,
    output logic [HASH_W-1:0]     hash,
    output logic [NREQ-1:0]       err,
    output logic                  busy,
    output logic                  core_rst,
    output logic                  core_start,
    output logic [BLK_W-1:0]      core_data,
    input  logic [HASH_W-1:0]     core_hash,
    input  logic                  core_done
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("sha_arbiter: unsupported NREQ or TIMEOUT");
    end

    state_t              state;
    state_t              state_d;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    next_ptr;
    logic [NREQ-1:0]     win;
    logic [NREQ-1:0]     gnt_d;
    logic [NREQ-1:0]     rsp_valid_d;
    logic [HASH_W-1:0]   hash_d;
    logic [BLK_W-1:0]    win_blk;
    logic [BLK_W-1:0]    core_data_d;
    logic                core_rst_d;
    logic                core_start_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PTR_W(PTR_W)
    ) u_rr (
        .req(req),
        .ptr(ptr),
        .win(win)
    );

    always_comb begin
        win_blk = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_blk = blk[i*BLK_W +: BLK_W];
            end
        end
    end

    // Pointer moves just past whoever currently holds the grant.
    always_comb begin
        next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                next_ptr = PTR_W'((i + 1) % NREQ);
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef SHA_ARB_TIMEOUT_EN
    logic [31:0]     wd_cnt;
    logic [31:0]     wd_cnt_d;
    logic [NREQ-1:0] err_q;
    logic [NREQ-1:0] err_d;

    assign err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= '0;
        end else begin
            wd_cnt <= wd_cnt_d;
            err_q  <= err_d;
        end
    end
`else
    assign err = '0;
`endif

    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        gnt_d        = gnt;
        rsp_valid_d  = rsp_valid;
        hash_d       = hash;
        core_data_d  = core_data;
        core_rst_d   = 1'b0;
        core_start_d = 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
        wd_cnt_d     = wd_cnt;
        err_d        = '0;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d       = win;
                    core_data_d = win_blk;
                    state_d     = CLR;
                end
            end
            CLR: begin
                core_rst_d = 1'b1;
                state_d    = START;
            end
            START: begin
                core_start_d = 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
                wd_cnt_d     = '0;
`endif
                state_d      = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    hash_d      = core_hash;
                    rsp_valid_d = gnt;
                    state_d     = RESP;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                // Core hung: report to the owner and recycle the core.
                else if (wd_cnt == 32'(TIMEOUT - 1)) begin
                    err_d      = gnt;
                    core_rst_d = 1'b1;
                    ptr_d      = next_ptr;
                    gnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + 32'd1;
                end
`endif
            end
            RESP: begin
                if (|(rsp_ack & rsp_valid)) begin
                    gnt_d       = '0;
                    rsp_valid_d = '0;
                    ptr_d       = next_ptr;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            hash       <= '0;
            core_data  <= '0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            gnt        <= gnt_d;
            rsp_valid  <= rsp_valid_d;
            hash       <= hash_d;
            core_data  <= core_data_d;
            core_rst   <= core_rst_d;
            core_start <= core_start_d;
        end
    end

endmodule

// File: tb/tb_sha_arbiter.sv
// Scoreboard bench for sha_arbiter with a behavioural SHA core model.
// Define SHA_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=16).
module tb_sha_arbiter;

    localparam int N = 2;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*512-1:0] blk = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ack = '0;
    logic [255:0]   hash;
    logic [N-1:0]   err;
    logic           busy;
    logic           core_rst;
    logic           core_start;
    logic [511:0]   core_data;
    logic [255:0]   core_hash = '0;
    logic           core_done = 1'b0;

    int total = 0;
    int bad = 0;
    int exp_ptr = 0;
    int core_lat = 2;
    bit core_hang = 1'b0;
    logic [255:0] last_hash = '0;

    typedef struct {
        int           idx;
        logic [255:0] h;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sha_arbiter #(.NREQ(N), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .blk(blk),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .hash(hash), .err(err), .busy(busy), .core_rst(core_rst),
        .core_start(core_start), .core_data(core_data),
        .core_hash(core_hash), .core_done(core_done)
    );

    function automatic logic [255:0] mhash(input logic [511:0] d);
        if (d == ABC_BLK) return ABC_HASH;
        return d[511:256] ^ d[255:0] ^ {8{32'h5a5aa5a5}};
    endfunction

    function automatic logic [511:0] rblk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Behavioural core: answers each start pulse after core_lat cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (core_start && !core_hang) begin
                repeat (core_lat) @(posedge clk);
                #1;
                core_hash = mhash(core_data);
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_expected(input logic [N-1:0] r);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (exp_ptr + k) % N;
            if (r[i]) begin
                e.idx = i;
                e.h   = mhash(blk[i*512 +: 512]);
                sb.push_back(e);
            end
        end
    endtask

    task automatic serve(input int n);
        exp_t e;
        logic [N-1:0] oh;
        int cyc;
        for (int t = 0; t < n; t++) begin
            cyc = 0;
            while (rsp_valid == '0 && cyc < 200) begin
                tick();
                cyc++;
            end
            total++;
            if (rsp_valid == '0) begin
                bad++;
                $display("FAIL rsp_wait rsp_valid=%b want nonzero", rsp_valid);
                return;
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_empty size=0 want >0");
                return;
            end
            e  = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            total++;
            if (rsp_valid !== oh) begin
                bad++;
                $display("FAIL rsp_order got=%b want=%b", rsp_valid, oh);
            end
            total++;
            if (gnt !== oh) begin
                bad++;
                $display("FAIL gnt_hold got=%b want=%b", gnt, oh);
            end
            total++;
            if (hash !== e.h) begin
                bad++;
                $display("FAIL hash got=%h want=%h", hash, e.h);
            end
            tick();
            total++;
            if (rsp_valid !== oh) begin
                bad++;
                $display("FAIL rsp_hold got=%b want=%b", rsp_valid, oh);
            end
            rsp_ack = oh;
            req[e.idx] = 1'b0;
            tick();
            rsp_ack = '0;
            total++;
            if (rsp_valid !== '0 || gnt !== '0) begin
                bad++;
                $display("FAIL ack_clear rsp=%b gnt=%b want 0/0", rsp_valid, gnt);
            end
            last_hash = e.h;
            exp_ptr = (e.idx + 1) % N;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({gnt, rsp_valid, err, core_start, busy, core_rst} !== {{(3*N){1'b0}}, 3'b001}) begin
            bad++;
            $display("FAIL reset_ctl got=%b/%b/%b/%b/%b/%b want 0/0/0/0/0/1",
                     gnt, rsp_valid, err, core_start, busy, core_rst);
        end
        total++;
        if (hash !== '0 || core_data !== '0) begin
            bad++;
            $display("FAIL reset_data hash=%h data=%h want 0", hash, core_data);
        end
        reset = 1'b1;
        tick();
        total++;
        if (core_rst !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset core_rst=%b busy=%b want 0/0", core_rst, busy);
        end
    endtask

    task automatic test_abc();
        blk[511:0]    = ABC_BLK;
        blk[1023:512] = rblk();
        core_lat = 3;
        push_expected(2'b01);
        req = 2'b01;
        tick();
        total++;
        if (gnt !== 2'b01 || busy !== 1'b1 || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL abc_grant gnt=%b busy=%b rst=%b want 01/1/0", gnt, busy, core_rst);
        end
        total++;
        if (core_data !== ABC_BLK) begin
            bad++;
            $display("FAIL abc_data got=%h want=%h", core_data, ABC_BLK);
        end
        blk[511:0] = rblk();
        tick();
        total++;
        if (core_rst !== 1'b1 || core_start !== 1'b0) begin
            bad++;
            $display("FAIL abc_clr rst=%b start=%b want 1/0", core_rst, core_start);
        end
        tick();
        total++;
        if (core_rst !== 1'b0 || core_start !== 1'b1) begin
            bad++;
            $display("FAIL abc_start rst=%b start=%b want 0/1", core_rst, core_start);
        end
        tick();
        total++;
        if (core_start !== 1'b0 || core_data !== ABC_BLK) begin
            bad++;
            $display("FAIL abc_hold start=%b data=%h want 0/%h", core_start, core_data, ABC_BLK);
        end
        serve(1);
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        exp_ptr = 0;
        for (int r = 0; r < 2; r++) begin
            blk = {rblk(), rblk()};
            core_lat = $urandom_range(1, 5);
            push_expected(2'b11);
            req = 2'b11;
            serve(2);
        end
    endtask

    task automatic test_drop_req();
        exp_t e;
        int cyc;
        blk[511:0] = rblk();
        core_lat = 8;
        push_expected(2'b01);
        req = 2'b01;
        repeat (4) tick();
        req = 2'b00;
        rsp_ack = 2'b01;
        tick();
        tick();
        rsp_ack = 2'b00;
        total++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL early_ack busy=%b rsp=%b want 1/00", busy, rsp_valid);
        end
        cyc = 0;
        while (rsp_valid == '0 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (rsp_valid !== 2'b01) begin
            bad++;
            $display("FAIL drop_rsp got=%b want=01", rsp_valid);
        end
        e = sb.pop_front();
        total++;
        if (hash !== e.h) begin
            bad++;
            $display("FAIL drop_hash got=%h want=%h", hash, e.h);
        end
        rsp_ack = 2'b10;
        repeat (3) tick();
        total++;
        if (rsp_valid !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wrong_ack rsp=%b busy=%b want 01/1", rsp_valid, busy);
        end
        rsp_ack = 2'b01;
        tick();
        rsp_ack = 2'b00;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL drop_done busy=%b rsp=%b want 0/00", busy, rsp_valid);
        end
        last_hash = e.h;
        exp_ptr = 1;
    endtask

    task automatic test_done_ignored();
        core_hash = {8{32'hdeadbeef}};
        core_done = 1'b1;
        tick();
        tick();
        core_done = 1'b0;
        total++;
        if (hash !== last_hash || busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL idle_done hash=%h busy=%b want %h/0", hash, busy, last_hash);
        end
    endtask

`ifdef SHA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        core_hang = 1'b1;
        req = 2'b01;
        tick();
        repeat (17) tick();
        total++;
        if (err !== 2'b00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL to_early err=%b busy=%b want 00/1", err, busy);
        end
        tick();
        total++;
        if (err !== 2'b01 || core_rst !== 1'b1 || busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL to_fire err=%b rst=%b busy=%b rsp=%b want 01/1/0/00",
                     err, core_rst, busy, rsp_valid);
        end
        req = 2'b00;
        tick();
        total++;
        if (err !== 2'b00 || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse err=%b rst=%b want 00/0", err, core_rst);
        end
        exp_ptr = 1;
        core_hang = 1'b0;
        core_lat = 2;
        blk = {rblk(), rblk()};
        push_expected(2'b11);
        req = 2'b11;
        tick();
        total++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL to_ptr gnt=%b want=10", gnt);
        end
        serve(2);
    endtask
`else
    task automatic test_no_timeout();
        core_hang = 1'b1;
        req = 2'b01;
        repeat (40) tick();
        total++;
        if (err !== 2'b00 || busy !== 1'b1 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL no_wd err=%b busy=%b rsp=%b want 00/1/00", err, busy, rsp_valid);
        end
        req = 2'b00;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        exp_ptr = 0;
    endtask
`endif

    task automatic test_reset_mid();
        logic seen;
        core_hang = 1'b1;
        req = 2'b01;
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (gnt !== 2'b00 || busy !== 1'b0 || core_rst !== 1'b1 ||
            rsp_valid !== 2'b00 || err !== 2'b00 || core_start !== 1'b0) begin
            bad++;
            $display("FAIL async_rst gnt=%b busy=%b rst=%b rsp=%b err=%b",
                     gnt, busy, core_rst, rsp_valid, err);
        end
        total++;
        if (hash !== '0 || core_data !== '0) begin
            bad++;
            $display("FAIL async_data hash=%h data=%h want 0", hash, core_data);
        end
        req = 2'b00;
        tick();
        reset = 1'b1;
        core_hang = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid != '0 || err != '0 || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL stale_rsp activity=%b want 0", seen);
        end
        exp_ptr = 0;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_round_robin();
        test_drop_req();
        test_done_ignored();
`ifdef SHA_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
